apb_master_bridge: RTL and testbench

- Converts a simple valid/ready request/response port into APB transactions.
- One transaction in flight at a time.
- Sits directly upstream of the APB GPIO peripheral: CPU-side requests drive that slave's paddr/psel/penable/pwrite/pwdata, and its prdata returns to the requester.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_bridge.sv | 94 +++++++++
 tb/tb_apb_master_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding, default bus widths
// and the register map of the downstream GPIO slave.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 8;

  localparam logic [7:0] GPIO_DATA_ADDR = 8'hF0;
  localparam logic [7:0] GPIO_CFG_ADDR  = 8'hF1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB master bridge, one transfer in flight at a time.
// Define APB_PREADY_EN to add a pready input that stretches the ACCESS phase.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
`ifdef APB_PREADY_EN
  input  logic                  pready,
`endif
  input  logic [DATA_WIDTH-1:0] prdata
);

  apb_state_e state;
  logic       access_done;

`ifdef APB_PREADY_EN
  assign access_done = pready;
`else
  assign access_done = 1'b1;
`endif

  assign req_ready = (state == IDLE);

  // APB outputs are set on the edge that enters each state, so they are valid for
  // the whole SETUP/ACCESS cycle rather than one cycle late.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr   <= req_addr;
            pwrite  <= req_write;
            pwdata  <= req_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (access_done) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_rdata <= pwrite ? '0 : prdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          psel       <= 1'b0;
          penable    <= 1'b0;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with a small GPIO slave model
// and a passive APB protocol monitor.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_rdata;
  logic [7:0] paddr, pwdata, prdata;
  logic       psel, penable, pwrite;
  logic       pready;

  int errors = 0;
  int checks = 0;

  // GPIO slave model state
  logic [7:0] gpio_out = 8'h00;
  logic [7:0] gpio_cfg = 8'h00;
  logic [7:0] gpio_in  = 8'h00;
  int         wait_left = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
`ifdef APB_PREADY_EN
    .pready     (pready),
`endif
    .prdata     (prdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: wait states while wait_left>0; read data is a poison value until pready.
  assign pready = (wait_left == 0);
  always_comb begin
    prdata = 8'hEE;
    if (pready) begin
      if (paddr == GPIO_DATA_ADDR)     prdata = gpio_in;
      else if (paddr == GPIO_CFG_ADDR) prdata = gpio_cfg;
      else                             prdata = 8'h00;
    end
  end

  always @(posedge pclk) begin
    if (psel && penable && !pready) wait_left <= wait_left - 1;
    if (presetn && psel && penable && pready && pwrite) begin
      if (paddr == GPIO_DATA_ADDR) gpio_out <= pwdata;
      if (paddr == GPIO_CFG_ADDR)  gpio_cfg <= pwdata;
    end
  end

  // Protocol monitor
  logic       prev_setup = 1'b0, prev_psel = 1'b0;
  logic [7:0] saddr = 8'h00, swdata = 8'h00;
  always @(negedge pclk) begin
    if (!presetn) begin
      prev_setup = 1'b0;
      prev_psel  = 1'b0;
    end else begin
      if (prev_setup) check("setup_then_access", {psel, penable}, 2'b11);
      if (psel && !penable) begin
        check("single_setup", prev_psel, 1'b0);
        saddr  = paddr;
        swdata = pwdata;
      end
      if (psel && penable) begin
        check("acc_has_psel_before", prev_psel, 1'b1);
        check("paddr_stable", paddr, saddr);
        check("pwdata_stable", pwdata, swdata);
      end
      if (req_ready || resp_valid) check("psel_idle_resp", psel, 1'b0);
      prev_setup = psel & ~penable;
      prev_psel  = psel;
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Present one request, wait for the accept edge, then count cycles to resp_valid.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       output int lat);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    lat = 0;
    while (!req_ready && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int pen_cycles;
  int stray;

  initial begin
    presetn    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 8'h00;
    resp_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_paddr", paddr, 8'h00);
    check("rst_pwdata", pwdata, 8'h00);
    check("rst_resp_rdata", resp_rdata, 8'h00);
    presetn = 1'b1;
    tick();

    // Write config then read it back
    issue(1'b1, GPIO_CFG_ADDR, 8'hFF, lat);
    check("wr_latency", lat, 3);
    check("wr_resp_valid", resp_valid, 1'b1);
    check("wr_rdata_zero", resp_rdata, 8'h00);
    check("wr_cfg_reg", gpio_cfg, 8'hFF);
    check("wr_no_data_reg", gpio_out, 8'h00);
    tick();
    check("wr_back_idle", req_ready, 1'b1);
    check("wr_resp_drop", resp_valid, 1'b0);

    issue(1'b0, GPIO_CFG_ADDR, 8'h00, lat);
    check("rd_latency", lat, 3);
    check("rd_rdata", resp_rdata, 8'hFF);
    tick();

    // Response backpressure with a competing request held high
    resp_ready = 1'b0;
    gpio_in    = 8'hA5;
    issue(1'b0, GPIO_DATA_ADDR, 8'h00, lat);
    check("bp_latency", lat, 3);
    req_valid = 1'b1;
    req_addr  = 8'h33;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", resp_valid, 1'b1);
      check("bp_resp_rdata", resp_rdata, 8'hA5);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_paddr_held", paddr, GPIO_DATA_ADDR);
      if (i < 4) tick();
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    tick();
    check("bp_release_valid", resp_valid, 1'b0);
    check("bp_release_ready", req_ready, 1'b1);
    check("bp_no_accept", psel, 1'b0);

    // Request inputs change after accept
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = GPIO_DATA_ADDR;
    tick();
    req_valid = 1'b0;
    req_addr  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("latch_paddr", paddr, GPIO_DATA_ADDR);
      check("latch_psel", psel, (i < 2) ? 1'b1 : 1'b0);
      tick();
    end
    check("latch_back_idle", req_ready, 1'b1);

    // Reset during ACCESS
    gpio_in = 8'h77;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = GPIO_DATA_ADDR;
    tick();
    req_valid = 1'b0;
    tick();
    check("abort_in_access", {psel, penable}, 2'b11);
    presetn = 1'b0;
    tick();
    check("abort_psel", psel, 1'b0);
    check("abort_penable", penable, 1'b0);
    check("abort_resp_valid", resp_valid, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    presetn = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid) stray++;
    end
    check("abort_no_resp", stray, 0);

`ifdef APB_PREADY_EN
    // Wait states on a read
    gpio_in   = 8'h3C;
    wait_left = 3;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = GPIO_DATA_ADDR;
    tick();
    req_valid  = 1'b0;
    pen_cycles = 0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
      if (penable) pen_cycles++;
    end
    check("pr_latency", lat, 6);
    check("pr_penable_cycles", pen_cycles, 4);
    check("pr_rdata", resp_rdata, 8'h3C);
    tick();
`else
    pen_cycles = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
